axil_reg_slave: RTL and testbench

AXI4-Lite slave register file that answers the AXI4-Lite master BFM transactions used throughout our IP example designs. It decodes single-beat writes and reads into a bank of NUM_REGS 32-bit registers and returns OKAY or SLVERR responses. It exposes the register contents and per-register write pulses to the user logic of the IP (e.g. interleaver buffer control). It is the responder end of the same S00_AXI interface the example test drives.

---
 rtl/axil_reg_slave.sv | 184 ++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers to user logic.
// Write and read channels run as independent FSMs; every output is registered.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs;
    logic             aw_in_range, ar_in_range;
    logic [IDX_W-1:0] aw_idx, ar_idx;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // In range exactly when every address bit above the word index is zero.
    assign aw_in_range = (aw_addr_q[ADDR_WIDTH-1:2+IDX_W] == '0);
    assign ar_in_range = (S_AXI_ARADDR[ADDR_WIDTH-1:2+IDX_W] == '0);
    assign aw_idx      = aw_addr_q[2 +: IDX_W];
    assign ar_idx      = S_AXI_ARADDR[2 +: IDX_W];

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], aw_addr_q[1:0]};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) w_state_next = W_COMMIT;
            W_COMMIT: w_state_next = W_RESP;
            W_RESP:   if (S_AXI_BREADY) w_state_next = W_IDLE;
            default:  w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_RESP;
            R_RESP:  if (S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Write channel: holding registers, register bank update and B response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            reg_wr_pulse  <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            reg_wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= S_AXI_AWADDR;
                        aw_held   <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                        w_held  <= 1'b1;
                    end
                    S_AXI_AWREADY <= (w_state_next == W_IDLE) && !(aw_held || aw_hs);
                    S_AXI_WREADY  <= (w_state_next == W_IDLE) && !(w_held || w_hs);
                end
                W_COMMIT: begin
                    if (aw_in_range) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wstrb_q[b]) regs[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                        reg_wr_pulse[aw_idx] <= 1'b1;
                        S_AXI_BRESP          <= RESP_OKAY;
                    end else begin
                        S_AXI_BRESP <= RESP_SLVERR;
                    end
                    S_AXI_BVALID <= 1'b1;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read channel: captures the pre-write value when a commit shares the edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= !ar_hs;
                    if (ar_hs) begin
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RDATA  <= ar_in_range ? regs[ar_idx] : '0;
                        S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out[DATA_WIDTH*k +: DATA_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized and directed bench for axil_reg_slave: drivers push expected
// responses into queues, independent monitors pop and compare them.
module tb_axil_reg_slave;

    localparam int NUM_REGS = 4;
    localparam int TMO      = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic [31:0]              awaddr, wdata, araddr, rdata;
    logic [2:0]               awprot, arprot;
    logic [3:0]               wstrb;
    logic                     awvalid, awready, wvalid, wready;
    logic [1:0]               bresp, rresp;
    logic                     bvalid, bready, arvalid, arready, rvalid, rready;
    logic [NUM_REGS*32-1:0]   reg_out;
    logic [NUM_REGS-1:0]      reg_wr_pulse;

    axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NUM_REGS)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    int checks = 0;
    int errors = 0;
    int b_done = 0;
    int r_done = 0;

    logic [1:0]          b_exp_q[$];
    logic [NUM_REGS-1:0] pulse_exp_q[$];
    logic [33:0]         r_exp_q[$];
    logic [31:0]         model_regs[NUM_REGS];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT response within %0d cycles, expected one", name, TMO);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_REGS*32-1:0] model_packed();
        logic [NUM_REGS*32-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[32*k +: 32] = model_regs[k];
        return v;
    endfunction

    // B monitor: compares every write response at its handshake.
    initial begin : b_monitor
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bvalid && bready) begin
                if (b_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bresp_unexpected: got %b expected no response", bresp);
                end else begin
                    e = b_exp_q.pop_front();
                    check("bresp", bresp, e);
                end
                b_done++;
            end
        end
    end

    // R monitor: compares read data and response at the handshake.
    initial begin : r_monitor
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rvalid && rready) begin
                if (r_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rresp_unexpected: got %b/%h expected no response", rresp, rdata);
                end else begin
                    e = r_exp_q.pop_front();
                    check("rresp", rresp, e[33:32]);
                    check("rdata", rdata, e[31:0]);
                end
                r_done++;
            end
        end
    end

    // Pulse monitor: a write pulse must appear exactly with the rising edge of BVALID.
    initial begin : pulse_monitor
        logic                prev;
        logic [NUM_REGS-1:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bvalid && !prev) begin
                    if (pulse_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pulse_unexpected_commit: got %b expected none", reg_wr_pulse);
                    end else begin
                        e = pulse_exp_q.pop_front();
                        check("reg_wr_pulse", reg_wr_pulse, e);
                    end
                end else if (reg_wr_pulse != '0) begin
                    checks++; errors++;
                    $display("FAIL pulse_spurious: got %b expected 0", reg_wr_pulse);
                end
                prev = bvalid;
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int                  start;
        int                  t;
        int                  idx;
        logic [NUM_REGS-1:0] p;
        p = '0;
        if (addr < NUM_REGS * 4) begin
            idx = int'(addr / 4);
            for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
            p[idx] = 1'b1;
            b_exp_q.push_back(2'b00);
        end else begin
            b_exp_q.push_back(2'b10);
        end
        pulse_exp_q.push_back(p);
        start = b_done;
        fork
            begin
                int ta;
                repeat (aw_dly) tick();
                awaddr = addr; awvalid = 1'b1;
                ta = 0;
                do begin @(negedge clk); ta++; end while (!awready && ta < TMO);
                if (!awready) timeout_fail("awready");
                tick();
                awvalid = 1'b0;
            end
            begin
                int tw;
                repeat (w_dly) tick();
                wdata = data; wstrb = strb; wvalid = 1'b1;
                tw = 0;
                do begin @(negedge clk); tw++; end while (!wready && tw < TMO);
                if (!wready) timeout_fail("wready");
                tick();
                wvalid = 1'b0;
            end
        join
        if (b_dly > 0) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!bvalid && t < TMO);
            if (!bvalid) timeout_fail("bvalid");
            repeat (b_dly) begin
                @(negedge clk);
                check("bvalid_hold", bvalid, 1'b1);
                check("awready_during_b", awready, 1'b0);
            end
            tick();
        end
        bready = 1'b1;
        t = 0;
        do begin @(posedge clk); t++; end while (b_done == start && t < TMO);
        if (b_done == start) timeout_fail("b_handshake");
        #1 bready = 1'b0;
        check("reg_out_after_write", reg_out, model_packed());
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly);
        int start;
        int t;
        if (addr < NUM_REGS * 4) r_exp_q.push_back({2'b00, model_regs[int'(addr / 4)]});
        else                     r_exp_q.push_back({2'b10, 32'h0});
        start = r_done;
        araddr = addr; arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < TMO);
        if (!arready) timeout_fail("arready");
        tick();
        arvalid = 1'b0;
        if (r_dly > 0) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!rvalid && t < TMO);
            if (!rvalid) timeout_fail("rvalid");
            repeat (r_dly) begin
                @(negedge clk);
                check("rvalid_hold", rvalid, 1'b1);
                check("arready_during_r", arready, 1'b0);
            end
            tick();
        end
        rready = 1'b1;
        t = 0;
        do begin @(posedge clk); t++; end while (r_done == start && t < TMO);
        if (r_done == start) timeout_fail("r_handshake");
        #1 rready = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] a;
        int          t;
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;

        // Reset release
        #483;
        check("reset_readies", {awready, wready, arready}, 3'b000);
        check("reset_valids", {bvalid, rvalid, bresp, rresp}, 6'b0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_reg_out", reg_out, model_packed());
        #19 rst = 1'b0;
        #1 check("readies_before_first_edge", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("readies_after_first_edge", {awready, wready, arready}, 3'b111);
        tick();

        // Four write/read pairs
        axi_write(32'h0, 32'h0101FFFF, 4'hF, 0, 0, 0); axi_read(32'h0, 0);
        axi_write(32'h4, 32'hABCD0001, 4'hF, 0, 0, 0); axi_read(32'h4, 0);
        axi_write(32'h8, 32'hDEAD0011, 4'hF, 0, 0, 0); axi_read(32'h8, 0);
        axi_write(32'hC, 32'hBEEF0011, 4'hF, 0, 0, 0); axi_read(32'hC, 0);

        // Skewed AW/W with a stalled response channel
        axi_write(32'h8, 32'h11223344, 4'hF, 0, 3, 5); axi_read(32'h8, 2);
        axi_write(32'hC, 32'h55667788, 4'hF, 3, 0, 5); axi_read(32'hC, 0);

        // Byte strobes
        axi_write(32'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_write(32'h4, 32'h12345678, 4'b0101, 0, 0, 0);
        axi_read(32'h4, 0);
        check("strobe_merge_model", model_regs[1], 32'hFF34FF78);
        axi_write(32'h0, 32'hCAFEBABE, 4'h0, 0, 0, 0);
        axi_read(32'h0, 0);

        // Out of range
        axi_write(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        axi_read(32'h10, 0);
        axi_read(32'h1C, 1);

        // Randomized mix, including unaligned and out-of-range addresses
        for (int i = 0; i < 60; i++) begin
            a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3));
        end

        // Reset while a write response and a read response are both pending
        awaddr = 32'h8; wdata = 32'h0F0F0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h4; arvalid = 1'b1;
        pulse_exp_q.push_back(4'b0100);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!(bvalid && rvalid) && t < TMO);
        check("both_pending", {bvalid, rvalid}, 2'b11);
        #2 rst = 1'b1;
        #1 check("async_reset_valids", {bvalid, rvalid}, 2'b00);
        check("async_reset_reg_out", reg_out, '0);
        b_exp_q.delete();
        r_exp_q.delete();
        for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        for (int k = 0; k < NUM_REGS; k++) axi_read(32'(4 * k), 0);

        repeat (3) tick();
        check("b_queue_drained", b_exp_q.size(), 0);
        check("r_queue_drained", r_exp_q.size(), 0);
        check("pulse_queue_drained", pulse_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
